alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WORD_WIDTH, default 8, ALU operand/result and register width.
REQ-002 Parameter OPCODE_WIDTH, default 4, ALU opcode width.
REQ-003 Parameter REG_ADDR_WIDTH, default 3, register index width (8 registers).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 instr_valid  input  1  instruction offered.
REQ-007 instr  input  16  [15:12] opCode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] ignored.
REQ-008 instr_ready  output  1  sequencer accepts instruction this cycle.
REQ-009 done  output  1  one-cycle pulse, instruction retired.
REQ-010 result  output  WORD_WIDTH  last retired ALU result, registered.
REQ-011 zero_flag  output  1  last retired ALU zero flag, registered.
REQ-012 dbg_addr  input  REG_ADDR_WIDTH  debug read index.
REQ-013 dbg_data  output  WORD_WIDTH  combinational read of register dbg_addr.

Function
REQ-014 FSM states SHALL be IDLE, READ, EXEC, WB; instr_ready SHALL be 1 only in IDLE.
REQ-015 Handshake SHALL occur on an edge where instr_valid && instr_ready; instr SHALL be latched then, and IDLE->READ.
REQ-016 READ SHALL latch register[rs1] into operand1 and register[rs2] into operand2; READ->EXEC unconditionally.
REQ-017 EXEC SHALL drive the alu sub-module with latched operands and opCode and latch its result and zero_flag; EXEC->WB.
REQ-018 WB SHALL assert done for exactly that cycle, write result into register[rd] at the closing edge, update result/zero_flag outputs, then WB->IDLE.
REQ-019 Latency SHALL be fixed: handshake at edge E0 -> done high during the cycle after E2 -> instr_ready high again after E3; throughput one instruction per 4 cycles.
REQ-020 instr_valid while not in IDLE SHALL be ignored; instr changes after handshake SHALL not affect the in-flight instruction.
REQ-021 All 2**OPCODE_WIDTH opcodes SHALL be passed unmodified to the alu; no opcode is illegal.
REQ-022 rd equal to rs1 or rs2 SHALL read old values (read precedes write); the next instruction SHALL see the new value.
REQ-023 Arithmetic width and overflow SHALL be those of the alu; results SHALL be truncated to WORD_WIDTH.
REQ-024 result and zero_flag SHALL hold between WB cycles.

Reset
REQ-025 reset SHALL force IDLE, clear all registers, operand latches, result and zero_flag to 0, done to 0, instr_ready to 1 in the following cycle.
REQ-026 reset during READ/EXEC/WB SHALL abort the instruction: no register write, no done pulse.
REQ-027 reset SHALL take priority over a simultaneous handshake.

Configuration
REQ-028 Macro ALU_SEQ_R0_ZERO_EN defined: register 0 SHALL always read 0 (operand and dbg_data), writes to rd=0 SHALL be discarded, done still pulses and result still updates.
REQ-029 Macro undefined: register 0 SHALL be an ordinary read/write register.

Structure
REQ-030 Shared package alu_pkg SHALL hold WORD_WIDTH/OPCODE_WIDTH constants, opcode encodings (4'h0 ADD, 4'h1 SUB), instruction field positions, and the FSM state typedef.
REQ-031 One sub-module regfile (2 async read ports + debug read, 1 sync write port) SHALL be used; the existing alu SHALL be instantiated, not re-implemented.

Verification
REQ-032 Reset, then dbg_addr sweep 0..7 -> all dbg_data = 0, instr_ready = 1, done = 0.
REQ-033 Preload r1=5, r2=3 via ADD chains; ADD rd=3,rs1=1,rs2=2 -> done exactly 3 cycles after handshake, result=8, zero_flag=0, r3=8.
REQ-034 SUB rd=4,rs1=1,rs2=1 -> result=0, zero_flag=1; r1=0, r2=255 ADD -> result=255; r2=255 plus r6=1 ADD -> result=0 (wrap), zero_flag=1.
REQ-035 Hold instr_valid high continuously with changing instr -> exactly one acceptance per 4 cycles, ignored words leave no trace.
REQ-036 Assert reset during EXEC of ADD rd=5 -> r5 stays 0, no done pulse, instr_ready=1 next cycle.
REQ-037 ADD rd=0 with r1=5,r2=3 -> with ALU_SEQ_R0_ZERO_EN dbg_data(0)=0, result=8; without it dbg_data(0)=8.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer slice.
// Contents: word/opcode/register-index widths, opcode encodings,
// instruction field positions, FSM state encoding and an instruction builder.
package alu_pkg;

   localparam int WORD_WIDTH     = 8;
   localparam int OPCODE_WIDTH   = 4;
   localparam int REG_ADDR_WIDTH = 3;
   localparam int INSTR_WIDTH    = 16;

   // Instruction layout: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] unused
   localparam int OPC_LSB = 12;
   localparam int RD_LSB  = 9;
   localparam int RS1_LSB = 6;
   localparam int RS2_LSB = 3;

   // Opcode encodings understood by the alu
   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_INC   = 4'h2;
   localparam logic [3:0] OP_AND   = 4'h3;
   localparam logic [3:0] OP_OR    = 4'h4;
   localparam logic [3:0] OP_XOR   = 4'h5;
   localparam logic [3:0] OP_NOT   = 4'h6;
   localparam logic [3:0] OP_PASSA = 4'h7;

   // Sequencer FSM state encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_READ = 2'd1;
   localparam state_t ST_EXEC = 2'd2;
   localparam state_t ST_WB   = 2'd3;

   // Assemble a 16-bit instruction word from its fields
   function automatic logic [15:0] mk_instr(input logic [3:0] opc, input logic [2:0] rd,
                                            input logic [2:0] rs1, input logic [2:0] rs2);
      mk_instr = {opc, rd, rs1, rs2, 3'b000};
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake and retirement bus of the ALU sequencer.
// master = instruction issuer, slave = sequencer.
interface alu_sequencer_if #(
   parameter int WORD_WIDTH = alu_pkg::WORD_WIDTH
);
   logic                  instr_valid;
   logic [15:0]           instr;
   logic                  instr_ready;
   logic                  done;
   logic [WORD_WIDTH-1:0] result;
   logic                  zero_flag;

   modport master (output instr_valid, output instr,
                   input  instr_ready, input done, input result, input zero_flag);
   modport slave  (input  instr_valid, input instr,
                   output instr_ready, output done, output result, output zero_flag);
endinterface

// File: rtl/alu.sv
// Existing combinational ALU: result and zero flag for every opcode value.
// Unlisted opcodes pass operand A through, so no opcode is illegal.
module alu #(
   parameter int WORD_WIDTH   = alu_pkg::WORD_WIDTH,
   parameter int OPCODE_WIDTH = alu_pkg::OPCODE_WIDTH
) (
   input  logic [OPCODE_WIDTH-1:0] opcode_i,
   input  logic [WORD_WIDTH-1:0]   a_i,
   input  logic [WORD_WIDTH-1:0]   b_i,
   output logic [WORD_WIDTH-1:0]   result_o,
   output logic                    zero_o
);
   import alu_pkg::*;

   logic [WORD_WIDTH-1:0] res_s;

   // Opcode decode; arithmetic wraps modulo 2**WORD_WIDTH
   always_comb begin
      res_s = '0;
      case (opcode_i)
         OP_ADD:   res_s = a_i + b_i;
         OP_SUB:   res_s = a_i - b_i;
         OP_INC:   res_s = a_i + {{(WORD_WIDTH-1){1'b0}}, 1'b1};
         OP_AND:   res_s = a_i & b_i;
         OP_OR:    res_s = a_i | b_i;
         OP_XOR:   res_s = a_i ^ b_i;
         OP_NOT:   res_s = ~a_i;
         OP_PASSA: res_s = a_i;
         default:  res_s = a_i;
      endcase
   end

   assign result_o = res_s;
   assign zero_o   = (res_s == '0);
endmodule

// File: rtl/alu_sequencer_regfile.sv
// Register file: two async read ports, one async debug read, one sync write.
// Optional macro ALU_SEQ_R0_ZERO_EN: register 0 reads as zero, writes to it dropped.
module alu_sequencer_regfile #(
   parameter int WORD_WIDTH     = alu_pkg::WORD_WIDTH,
   parameter int REG_ADDR_WIDTH = alu_pkg::REG_ADDR_WIDTH
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] dbg_addr_i,
   input  logic                      wr_en_i,
   input  logic [REG_ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [WORD_WIDTH-1:0]     wr_data_i,
   output logic [WORD_WIDTH-1:0]     rs1_data_o,
   output logic [WORD_WIDTH-1:0]     rs2_data_o,
   output logic [WORD_WIDTH-1:0]     dbg_data_o
);
   localparam int NREGS = 2 ** REG_ADDR_WIDTH;

   logic [WORD_WIDTH-1:0] regs_q [NREGS];
   logic                  wr_block_s;

`ifdef ALU_SEQ_R0_ZERO_EN
   assign wr_block_s = (wr_addr_i == '0);
   assign rs1_data_o = (rs1_addr_i == '0) ? '0 : regs_q[rs1_addr_i];
   assign rs2_data_o = (rs2_addr_i == '0) ? '0 : regs_q[rs2_addr_i];
   assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];
`else
   assign wr_block_s = 1'b0;
   assign rs1_data_o = regs_q[rs1_addr_i];
   assign rs2_data_o = regs_q[rs2_addr_i];
   assign dbg_data_o = regs_q[dbg_addr_i];
`endif

   // Register storage: cleared on reset, single write port otherwise
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en_i && !wr_block_s) begin
         regs_q[wr_addr_i] <= wr_data_i;
      end
   end
endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer top: IDLE -> READ -> EXEC -> WB, one instruction per 4 cycles.
// Optional macro ALU_SEQ_R0_ZERO_EN makes register 0 a hard-wired zero.
module alu_sequencer #(
   parameter int WORD_WIDTH     = alu_pkg::WORD_WIDTH,
   parameter int OPCODE_WIDTH   = alu_pkg::OPCODE_WIDTH,
   parameter int REG_ADDR_WIDTH = alu_pkg::REG_ADDR_WIDTH
) (
   input  logic                      clock,
   input  logic                      reset,
   alu_sequencer_if.slave            bus,
   input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
   output logic [WORD_WIDTH-1:0]     dbg_data
);
   import alu_pkg::*;

   state_t                    state_q, state_d;
   logic [OPCODE_WIDTH-1:0]   opc_q;
   logic [REG_ADDR_WIDTH-1:0] rd_q, rs1_q, rs2_q;
   logic [WORD_WIDTH-1:0]     op1_q, op2_q, alu_res_q, result_q;
   logic                      alu_zero_q, zero_q, done_q;

   logic                      hs_s;
   logic [WORD_WIDTH-1:0]     rs1_data_s, rs2_data_s, alu_res_s;
   logic                      alu_zero_s;

   assign hs_s = bus.instr_valid && (state_q == ST_IDLE);

   alu_sequencer_regfile #(
      .WORD_WIDTH     (WORD_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_regfile (
      .clock      (clock),
      .reset      (reset),
      .rs1_addr_i (rs1_q),
      .rs2_addr_i (rs2_q),
      .dbg_addr_i (dbg_addr),
      .wr_en_i    (state_q == ST_WB),
      .wr_addr_i  (rd_q),
      .wr_data_i  (alu_res_q),
      .rs1_data_o (rs1_data_s),
      .rs2_data_o (rs2_data_s),
      .dbg_data_o (dbg_data)
   );

   alu #(
      .WORD_WIDTH   (WORD_WIDTH),
      .OPCODE_WIDTH (OPCODE_WIDTH)
   ) u_alu (
      .opcode_i (opc_q),
      .a_i      (op1_q),
      .b_i      (op2_q),
      .result_o (alu_res_s),
      .zero_o   (alu_zero_s)
   );

   // Next-state logic: only IDLE waits, the other states advance every cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (hs_s) begin
               state_d = ST_READ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: state_d = ST_EXEC;
         ST_EXEC: state_d = ST_WB;
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer datapath registers; reset wins over handshake and aborts in-flight work
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         opc_q      <= '0;
         rd_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
         alu_res_q  <= '0;
         alu_zero_q <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == ST_EXEC);
         if (hs_s) begin
            opc_q <= bus.instr[OPC_LSB +: OPCODE_WIDTH];
            rd_q  <= bus.instr[RD_LSB  +: REG_ADDR_WIDTH];
            rs1_q <= bus.instr[RS1_LSB +: REG_ADDR_WIDTH];
            rs2_q <= bus.instr[RS2_LSB +: REG_ADDR_WIDTH];
         end
         if (state_q == ST_READ) begin
            op1_q <= rs1_data_s;
            op2_q <= rs2_data_s;
         end
         if (state_q == ST_EXEC) begin
            alu_res_q  <= alu_res_s;
            alu_zero_q <= alu_zero_s;
         end
         if (state_q == ST_WB) begin
            result_q <= alu_res_q;
            zero_q   <= alu_zero_q;
         end
      end
   end

   assign bus.instr_ready = (state_q == ST_IDLE);
   assign bus.done        = done_q;
   assign bus.result      = result_q;
   assign bus.zero_flag   = zero_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes expected results,
// a negedge monitor pops them when done pulses and checks latency/result.
module tb_alu_sequencer;
   import alu_pkg::*;

   typedef struct {
      logic [7:0] r;
      logic       z;
      int         c0;
      string      nm;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] dbg_addr = 3'd0;
   logic [7:0] dbg_data;

   alu_sequencer_if bus ();

   alu_sequencer dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always #5 clock = ~clock;

   int   vectors = 0;
   int   fails   = 0;
   int   cyc     = 0;
   exp_t exp_q[$];
   logic pend    = 1'b0;
   exp_t pend_e;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // Monitor: on done, pop expectation and check latency; next negedge check result/zero
   always @(negedge clock) begin
      if (pend) begin
         chk({pend_e.nm, "_result"}, {24'd0, bus.result}, {24'd0, pend_e.r});
         chk({pend_e.nm, "_zero"}, {31'd0, bus.zero_flag}, {31'd0, pend_e.z});
         pend = 1'b0;
      end
      if (!reset && bus.done) begin
         if (exp_q.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            pend_e = exp_q.pop_front();
            chk({pend_e.nm, "_latency"}, cyc - pend_e.c0, 32'd2);
            pend = 1'b1;
         end
      end
   end

   // Issue one instruction when ready; expectation pushed at the handshake edge
   task automatic issue(input logic [15:0] w, input logic [7:0] er, input logic ez, input string nm);
      exp_t e;
      int   n = 0;
      while (!bus.instr_ready && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      if (n >= 20) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
      bus.instr_valid = 1'b1;
      bus.instr       = w;
      @(posedge clock); #1;
      e.r = er; e.z = ez; e.c0 = cyc; e.nm = nm;
      exp_q.push_back(e);
      bus.instr_valid = 1'b0;
      bus.instr       = 16'hFFFF;
   endtask

   // Wait until all expectations have been checked and the sequencer is idle
   task automatic drain(input string nm);
      int n = 0;
      while ((exp_q.size() != 0 || pend || !bus.instr_ready) && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) chk({nm, "_drain_timeout"}, 32'd0, 32'd1);
      @(negedge clock);
   endtask

   task automatic chk_reg(input logic [2:0] a, input logic [7:0] req, input string nm);
      dbg_addr = a;
      #1;
      chk(nm, {24'd0, dbg_data}, {24'd0, req});
   endtask

   // Build r6=1, r7=2, r1=5, r2=3 starting from cleared registers
   task automatic preload();
      issue(mk_instr(OP_INC, 3'd6, 3'd0, 3'd0), 8'd1, 1'b0, "pre_r6");
      issue(mk_instr(OP_ADD, 3'd7, 3'd6, 3'd6), 8'd2, 1'b0, "pre_r7");
      issue(mk_instr(OP_ADD, 3'd1, 3'd7, 3'd7), 8'd4, 1'b0, "pre_r1a");
      issue(mk_instr(OP_ADD, 3'd1, 3'd1, 3'd6), 8'd5, 1'b0, "pre_r1b");
      issue(mk_instr(OP_ADD, 3'd2, 3'd7, 3'd6), 8'd3, 1'b0, "pre_r2");
      drain("pre");
      chk_reg(3'd1, 8'd5, "pre_r1");
      chk_reg(3'd2, 8'd3, "pre_r2v");
   endtask

   logic [15:0] cwords [9];
   logic [7:0]  cres   [9];

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr       = 16'h0000;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_result", {24'd0, bus.result}, 32'd0);
      for (int i = 0; i < 8; i++) chk_reg(i[2:0], 8'd0, "rst_reg");

      preload();
      issue(mk_instr(OP_ADD, 3'd3, 3'd1, 3'd2), 8'd8, 1'b0, "add_5p3");
      drain("add");
      chk_reg(3'd3, 8'd8, "r3_8");
      repeat (3) @(negedge clock);
      chk("hold_result", {24'd0, bus.result}, 32'd8);
      chk("hold_zero", {31'd0, bus.zero_flag}, 32'd0);

      issue(mk_instr(OP_SUB, 3'd4, 3'd1, 3'd1), 8'd0, 1'b1, "sub_self");
      issue(mk_instr(OP_SUB, 3'd2, 3'd0, 3'd6), 8'd255, 1'b0, "sub_neg1");
      issue(mk_instr(OP_SUB, 3'd1, 3'd1, 3'd1), 8'd0, 1'b1, "clr_r1");
      issue(mk_instr(OP_ADD, 3'd3, 3'd1, 3'd2), 8'd255, 1'b0, "add_0_255");
      issue(mk_instr(OP_ADD, 3'd3, 3'd2, 3'd6), 8'd0, 1'b1, "add_wrap");
      issue(mk_instr(OP_ADD, 3'd7, 3'd7, 3'd7), 8'd4, 1'b0, "rd_eq_rs");
      issue(mk_instr(OP_ADD, 3'd4, 3'd7, 3'd6), 8'd5, 1'b0, "sees_new");
      drain("arith");
      chk_reg(3'd3, 8'd0, "r3_wrap");
      chk_reg(3'd4, 8'd5, "r4_5");

      // Continuous valid: only words 0, 4, 8 are accepted; others would write r5
      for (int k = 0; k < 9; k++) begin
         cwords[k] = mk_instr(OP_INC, 3'd5, 3'd6, 3'd0);
         cres[k]   = 8'd0;
      end
      cwords[0] = mk_instr(OP_ADD, 3'd4, 3'd6, 3'd6); cres[0] = 8'd2;
      cwords[4] = mk_instr(OP_ADD, 3'd4, 3'd4, 3'd6); cres[4] = 8'd3;
      cwords[8] = mk_instr(OP_ADD, 3'd4, 3'd4, 3'd4); cres[8] = 8'd6;
      @(posedge clock); #1;
      bus.instr_valid = 1'b1;
      for (int k = 0; k < 9; k++) begin
         exp_t e;
         logic acc;
         bus.instr = cwords[k];
         acc = bus.instr_ready;
         chk("cont_ready", {31'd0, acc}, {31'd0, (k % 4 == 0)});
         @(posedge clock); #1;
         if (acc) begin
            e.r = cres[k]; e.z = 1'b0; e.c0 = cyc; e.nm = "cont";
            exp_q.push_back(e);
         end
      end
      bus.instr_valid = 1'b0;
      drain("cont");
      chk_reg(3'd4, 8'd6, "cont_r4");
      chk_reg(3'd5, 8'd0, "cont_r5_untouched");

      // Reset during EXEC aborts the instruction
      issue(mk_instr(OP_ADD, 3'd5, 3'd6, 3'd6), 8'd2, 1'b0, "abort");
      @(posedge clock); #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("abort_ready", {31'd0, bus.instr_ready}, 32'd1);
      chk("abort_done", {31'd0, bus.done}, 32'd0);
      repeat (4) @(negedge clock);
      chk_reg(3'd5, 8'd0, "abort_r5");
      chk("abort_result", {24'd0, bus.result}, 32'd0);

      // Write to register 0
      preload();
      issue(mk_instr(OP_ADD, 3'd0, 3'd1, 3'd2), 8'd8, 1'b0, "add_rd0");
      drain("rd0");
`ifdef ALU_SEQ_R0_ZERO_EN
      chk_reg(3'd0, 8'd0, "r0_hardzero");
`else
      chk_reg(3'd0, 8'd8, "r0_written");
`endif
      chk("sb_empty", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
